pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum cycles spent waiting for dmem_ready before abort.
REQ-002 SHALL have parameter CNT_W, default 32: width of each performance counter.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port arst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports id_rs1, id_rs2, input, 5 each: source registers of the instruction in IF/ID.
REQ-006 SHALL have port id_uses_rs2, input, 1: the ID instruction reads rs2.
REQ-007 SHALL have ports ex_rd (input, 5) and ex_memread (input, 1): destination register and load flag held in ID/EX.
REQ-008 SHALL have port mem_branch_taken, input, 1: the EX/MEM branch flag ANDed with zero.
REQ-009 SHALL have ports dmem_req (input, 1) and dmem_ready (input, 1): MEM-stage access request and data-memory completion.
REQ-010 SHALL have port err_clr, input, 1: clears mem_err.
REQ-011 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, output, 1 each: pipeline register enables.
REQ-012 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, output, 1 each: load a bubble (all zero) into the stage.
REQ-013 SHALL have port pc_sel_branch, output, 1: PC takes the EX/MEM branch target.
REQ-014 SHALL have port mem_err, output, 1: sticky memory-timeout flag.
REQ-015 SHALL have ports load_stall_cnt, flush_cnt, mem_wait_cnt, output, CNT_W each: performance counters.

Function
REQ-016 SHALL implement a two-state FSM, RUN and MEM_WAIT; outputs are combinational from state and inputs (Mealy), with no added pipeline latency.
REQ-017 Load-use hazard SHALL be ex_memread AND ex_rd != 0 AND (ex_rd == id_rs1 OR (id_uses_rs2 AND ex_rd == id_rs2)).
REQ-018 Memory stall SHALL be dmem_req AND NOT dmem_ready, in either state.
REQ-019 Priority SHALL be memory stall, then branch taken, then load-use.
REQ-020 Memory stall SHALL drive all five enables to 0 and mem_wb_flush to 1, with all other flushes 0 and pc_sel_branch 0.
REQ-021 Branch taken without a memory stall SHALL drive all enables to 1, if_id_flush, id_ex_flush, ex_mem_flush and pc_sel_branch to 1, and mem_wb_flush to 0.
REQ-022 Load-use alone SHALL drive pc_en = if_id_en = 0 and id_ex_flush = 1, with the remaining enables 1 and flushes 0; this is exactly one bubble per hazard.
REQ-023 With no condition active, all enables SHALL be 1, all flushes 0 and pc_sel_branch 0.
REQ-024 RUN SHALL go to MEM_WAIT on a memory stall; MEM_WAIT SHALL go to RUN when dmem_ready=1 or dmem_req=0.
REQ-025 wait_cnt SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle.
REQ-026 When wait_cnt == MEM_TIMEOUT while still stalled, the FSM SHALL set mem_err, return to RUN, and force that cycle's outputs to the no-condition values, so the access is dropped.
REQ-027 err_clr SHALL clear mem_err on the next edge; a simultaneous set SHALL win over the clear.

Reset
REQ-028 arst_n low SHALL immediately set the state to RUN and clear wait_cnt, mem_err and all counters.
REQ-029 During reset, outputs SHALL be the no-condition values: enables 1, flushes 0, pc_sel_branch 0.
REQ-030 Reset asserted mid-MEM_WAIT SHALL abort the wait without setting mem_err.

Configuration
REQ-031 Macro HAZARD_PERF_CNT_EN compiles in the counters:
- load_stall_cnt increments per REQ-022 cycle.
- flush_cnt increments per REQ-021 cycle.
- mem_wait_cnt increments per REQ-020 cycle.
- All three saturate at 2^CNT_W-1.
REQ-032 Without HAZARD_PERF_CNT_EN, the three counter outputs SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-033 ex_memread=1, ex_rd=5, id_rs1=5 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle; load_stall_cnt=1.
REQ-034 ex_memread=1, ex_rd=0, id_rs1=0 -> no stall; also ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall.
REQ-035 dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> enables 0 and mem_wb_flush=1 for 3 cycles, all enables 1 on the 4th; mem_wait_cnt=3.
REQ-036 mem_branch_taken=1 together with load-use -> three flushes and pc_sel_branch=1, id_ex_flush=1, pc_en=1; flush_cnt=1, load_stall_cnt=0.
REQ-037 MEM_TIMEOUT=4, dmem_ready held 0 -> mem_err=1 after the 5th wait cycle with the FSM in RUN; err_clr=1 -> mem_err=0 on the next edge.
REQ-038 arst_n pulsed low in the 2nd MEM_WAIT cycle -> state RUN, mem_err=0, all counters 0, outputs at no-condition values.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush and data-memory
// stall handling with a bounded wait and a sticky timeout flag.
// Outputs are Mealy (combinational from state and inputs).
// Optional: define HAZARD_PERF_CNT_EN to build the saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             mem_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             err_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_sel_branch,
  output logic             mem_err,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  localparam logic [0:0] StRun     = 1'b0;
  localparam logic [0:0] StMemWait = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              load_use, mem_stall, timeout, err_set;

  assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign mem_stall = dmem_req && !dmem_ready;
  assign timeout   = (state_q == StMemWait) && mem_stall && (wait_cnt_q == TIMEOUT_V);
  assign mem_err   = mem_err_q;

  // Prioritised stage control; reset and a timed-out access both yield the idle pattern.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_sel_branch = 1'b0;
    if (!arst_n || timeout) begin
      // keep defaults: the access is dropped
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mem_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      pc_sel_branch = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Next state, wait counter and sticky error flag.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_set    = 1'b0;
    case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      default: begin
        if (!mem_stall) begin
          state_d = StRun;
        end else if (timeout) begin
          state_d = StRun;
          err_set = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
    endcase
    // Set wins over a simultaneous clear.
    mem_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : mem_err_q);
  end

  // FSM state registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] load_stall_q, flush_q, mem_wait_q;
  logic             cyc_lu, cyc_br, cyc_mem;

  // Each action is uniquely identified by its output pattern.
  assign cyc_mem = mem_wb_flush;
  assign cyc_br  = pc_sel_branch;
  assign cyc_lu  = id_ex_flush && !pc_sel_branch;

  // Saturating event counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      load_stall_q <= '0;
      flush_q      <= '0;
      mem_wait_q   <= '0;
    end else begin
      if (cyc_lu && (load_stall_q != '1)) load_stall_q <= load_stall_q + CNT_W'(1);
      if (cyc_br && (flush_q != '1))      flush_q      <= flush_q + CNT_W'(1);
      if (cyc_mem && (mem_wait_q != '1))  mem_wait_q   <= mem_wait_q + CNT_W'(1);
    end
  end

  assign load_stall_cnt = load_stall_q;
  assign flush_cnt      = flush_q;
  assign mem_wait_cnt   = mem_wait_q;
`else
  assign load_stall_cnt = '0;
  assign flush_cnt      = '0;
  assign mem_wait_cnt   = '0;
`endif

endmodule
